// File: rtl/refresh_pkg.sv
// Shared types and helpers for the memory-wrapper refresh scheduler.
package refresh_pkg;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_WAIT,
        RS_START,
        RS_REFRESH,
        RS_NEXT
    } rs_state_e;

    // Widest bank array the one-hot decode can serve.
    localparam int MAX_BANKS   = 32;
    localparam int MAX_BANKS_W = $clog2(MAX_BANKS);

    function automatic logic [MAX_BANKS-1:0] onehot(input logic [MAX_BANKS_W-1:0] idx);
        logic [MAX_BANKS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Refresh handshake between the scheduler (master) and the bank wrappers (slave).
interface refresh_scheduler_if #(
    parameter int NUM_BANKS = 4
);

    logic [NUM_BANKS-1:0] start_sr;
    logic [NUM_BANKS-1:0] ref_en_cur;
    logic [NUM_BANKS-1:0] ref_en_old;
    logic [NUM_BANKS-1:0] ref_done;

    modport master (
        output start_sr,
        output ref_en_cur,
        output ref_en_old,
        input  ref_done
    );

    modport slave (
        input  start_sr,
        input  ref_en_cur,
        input  ref_en_old,
        output ref_done
    );

endinterface

// File: rtl/refresh_interval_counter.sv
// Loadable down-counter that saturates at zero and flags it; load wins over decrement.
module refresh_interval_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/refresh_scheduler.sv
// Round-robin refresh initiator: spaces bank refreshes by INTERVAL cycles, pulses start_SR,
// drives ref_en_current/ref_en_old and bounds each bank's refresh with a timeout.
module refresh_scheduler
    import refresh_pkg::*;
#(
    parameter int NUM_BANKS      = 4,
    parameter int RET_CYCLES     = 1024,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int BANK_W         = $clog2(NUM_BANKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_i,
    input  logic                        force_i,
    refresh_scheduler_if.master         bus,
    output logic [BANK_W-1:0]           cur_bank_o,
    output logic [BANK_W-1:0]           old_bank_o,
    output logic                        busy_o,
    output logic                        round_done_o,
    output logic                        timeout_err_o
);

    localparam int INTERVAL = RET_CYCLES / NUM_BANKS;
    localparam int IV_W     = $clog2(INTERVAL);
    localparam int TO_W     = $clog2(TIMEOUT_CYCLES);

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [IV_W-1:0]   IV_LOAD   = IV_W'(INTERVAL - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);

    rs_state_e         state_q, state_d;
    logic [BANK_W-1:0] cur_q, cur_d;
    logic [BANK_W-1:0] old_q, old_d;
    logic              old_valid_q, old_valid_d;
    logic              busy_q, busy_d;
    logic              round_done_q, round_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic iv_load, iv_dec, iv_zero;
    logic to_load, to_dec, to_zero;

    logic [NUM_BANKS-1:0] cur_oh;
    logic [NUM_BANKS-1:0] old_oh;
    logic                 cur_done;

    refresh_interval_counter #(
        .CNT_W (IV_W)
    ) u_interval_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (iv_load),
        .load_val_i (IV_LOAD),
        .dec_i      (iv_dec),
        .zero_o     (iv_zero)
    );

    refresh_interval_counter #(
        .CNT_W (TO_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (to_load),
        .load_val_i (TO_LOAD),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );

    assign cur_oh   = NUM_BANKS'(onehot(MAX_BANKS_W'(cur_q)));
    assign old_oh   = NUM_BANKS'(onehot(MAX_BANKS_W'(old_q)));
    // Masking with the current one-hot drops done strobes from every other bank.
    assign cur_done = |(bus.ref_done & cur_oh);

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        old_d         = old_q;
        old_valid_d   = old_valid_q;
        timeout_err_d = timeout_err_q;
        iv_load       = 1'b0;
        iv_dec        = 1'b0;
        to_load       = 1'b0;
        to_dec        = 1'b0;

        case (state_q)
            RS_IDLE: begin
                if (enable_i) begin
                    state_d = RS_WAIT;
                    iv_load = 1'b1;
                end
            end
            RS_WAIT: begin
                if (!enable_i) begin
                    state_d = RS_IDLE;
                end else if (iv_zero || force_i) begin
                    state_d = RS_START;
                end else begin
                    iv_dec = 1'b1;
                end
            end
            RS_START: begin
                to_load = 1'b1;
                state_d = RS_REFRESH;
            end
            RS_REFRESH: begin
                // A done arriving on the last allowed cycle still counts as clean.
                if (cur_done) begin
                    state_d = RS_NEXT;
                end else if (to_zero) begin
                    timeout_err_d = 1'b1;
                    state_d       = RS_NEXT;
                end else begin
                    to_dec = 1'b1;
                end
            end
            RS_NEXT: begin
                old_d       = cur_q;
                cur_d       = (cur_q == LAST_BANK) ? '0 : cur_q + 1'b1;
                old_valid_d = 1'b1;
                if (enable_i) begin
                    state_d = RS_WAIT;
                    iv_load = 1'b1;
                end else begin
                    state_d = RS_IDLE;
                end
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase

        busy_d       = (state_d == RS_START) || (state_d == RS_REFRESH) || (state_d == RS_NEXT);
        round_done_d = (state_d == RS_NEXT) && (cur_q == LAST_BANK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RS_IDLE;
            cur_q         <= '0;
            old_q         <= LAST_BANK;
            old_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            round_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            old_q         <= old_d;
            old_valid_q   <= old_valid_d;
            busy_q        <= busy_d;
            round_done_q  <= round_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Wrapper-facing strobes are decoded from the registered state and indices.
    always_comb begin
        bus.start_sr   = '0;
        bus.ref_en_cur = '0;
        bus.ref_en_old = '0;
        if (state_q == RS_START) begin
            bus.start_sr = cur_oh;
        end
        if ((state_q == RS_START) || (state_q == RS_REFRESH)) begin
            bus.ref_en_cur = cur_oh;
            if (old_valid_q) begin
                bus.ref_en_old = old_oh;
            end
        end
    end

    assign cur_bank_o    = cur_q;
    assign old_bank_o    = old_q;
    assign busy_o        = busy_q;
    assign round_done_o  = round_done_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler: 4 banks, INTERVAL=16, TIMEOUT_CYCLES=200.
module tb_refresh_scheduler;

    logic       clk;
    logic       rst;
    logic       enable_i;
    logic       force_i;
    logic [1:0] cur_bank_o;
    logic [1:0] old_bank_o;
    logic       busy_o;
    logic       round_done_o;
    logic       timeout_err_o;

    int n_checks;
    int n_fail;
    int lat;

    refresh_scheduler_if #(.NUM_BANKS(4)) bus ();

    refresh_scheduler #(
        .NUM_BANKS      (4),
        .RET_CYCLES     (64),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .force_i       (force_i),
        .bus           (bus),
        .cur_bank_o    (cur_bank_o),
        .old_bank_o    (old_bank_o),
        .busy_o        (busy_o),
        .round_done_o  (round_done_o),
        .timeout_err_o (timeout_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until a start pulse is seen, or -1 if none within max_cyc.
    task automatic wait_start(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (bus.start_sr != '0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        enable_i     = 1'b0;
        force_i      = 1'b0;
        bus.ref_done = '0;
        tick();
        tick();

        check("rst_start_sr", 32'(bus.start_sr), 32'h0);
        check("rst_ref_en_cur", 32'(bus.ref_en_cur), 32'h0);
        check("rst_ref_en_old", 32'(bus.ref_en_old), 32'h0);
        check("rst_cur_bank", 32'(cur_bank_o), 32'd0);
        check("rst_old_bank", 32'(old_bank_o), 32'd3);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_timeout_err", 32'(timeout_err_o), 32'd0);

        // Bank 0: first start comes INTERVAL+1 edges after enable is raised from IDLE.
        rst      = 1'b0;
        enable_i = 1'b1;
        wait_start(40, lat);
        check("b0_latency", 32'(lat), 32'd17);
        check("b0_start_sr", 32'(bus.start_sr), 32'h1);
        check("b0_ref_en_cur", 32'(bus.ref_en_cur), 32'h1);
        check("b0_ref_en_old", 32'(bus.ref_en_old), 32'h0);
        check("b0_busy", 32'(busy_o), 32'd1);
        tick();
        check("b0_refresh_start_sr", 32'(bus.start_sr), 32'h0);
        check("b0_refresh_en_cur", 32'(bus.ref_en_cur), 32'h1);
        repeat (128) tick();
        check("b0_still_refresh", 32'(bus.ref_en_cur), 32'h1);
        check("b0_no_err", 32'(timeout_err_o), 32'd0);
        bus.ref_done = 4'b0001;
        tick();
        bus.ref_done = '0;
        check("b0_next_en_cur", 32'(bus.ref_en_cur), 32'h0);
        check("b0_next_busy", 32'(busy_o), 32'd1);
        check("b0_next_round_done", 32'(round_done_o), 32'd0);
        tick();
        check("b0_after_cur_bank", 32'(cur_bank_o), 32'd1);
        check("b0_after_old_bank", 32'(old_bank_o), 32'd0);
        check("b0_after_busy", 32'(busy_o), 32'd0);

        // Bank 1: foreign done strobes must not end its refresh.
        wait_start(40, lat);
        check("b1_latency", 32'(lat), 32'd16);
        check("b1_start_sr", 32'(bus.start_sr), 32'h2);
        check("b1_ref_en_old", 32'(bus.ref_en_old), 32'h1);
        tick();
        bus.ref_done = 4'b0100;
        tick();
        tick();
        check("b1_foreign_done_ignored", 32'(bus.ref_en_cur), 32'h2);
        bus.ref_done = 4'b0010;
        tick();
        bus.ref_done = '0;
        check("b1_next_round_done", 32'(round_done_o), 32'd0);

        // Bank 2: done presented during START is not sampled.
        wait_start(40, lat);
        check("b2_latency", 32'(lat), 32'd17);
        check("b2_start_sr", 32'(bus.start_sr), 32'h4);
        check("b2_ref_en_old", 32'(bus.ref_en_old), 32'h2);
        bus.ref_done = 4'b0100;
        tick();
        bus.ref_done = '0;
        tick();
        check("b2_start_done_ignored", 32'(bus.ref_en_cur), 32'h4);
        bus.ref_done = 4'b0100;
        tick();
        bus.ref_done = '0;

        // Bank 3 closes the round.
        wait_start(40, lat);
        check("b3_start_sr", 32'(bus.start_sr), 32'h8);
        tick();
        bus.ref_done = 4'b1000;
        tick();
        bus.ref_done = '0;
        check("b3_round_done", 32'(round_done_o), 32'd1);
        tick();
        check("b3_round_done_pulse", 32'(round_done_o), 32'd0);
        check("wrap_cur_bank", 32'(cur_bank_o), 32'd0);
        check("wrap_old_bank", 32'(old_bank_o), 32'd3);

        // Bank 0 again: withhold done until the timeout forces an advance.
        wait_start(40, lat);
        check("to_latency", 32'(lat), 32'd16);
        check("to_ref_en_old", 32'(bus.ref_en_old), 32'h8);
        repeat (200) tick();
        check("to_last_refresh_cycle", 32'(bus.ref_en_cur), 32'h1);
        check("to_err_not_yet", 32'(timeout_err_o), 32'd0);
        tick();
        check("to_err_set", 32'(timeout_err_o), 32'd1);
        check("to_next_en_cur", 32'(bus.ref_en_cur), 32'h0);
        tick();
        check("to_cur_advanced", 32'(cur_bank_o), 32'd1);

        // Force at interval count 10 starts bank 1 on the next edge.
        repeat (5) tick();
        check("force_pre_start", 32'(bus.start_sr), 32'h0);
        force_i = 1'b1;
        tick();
        force_i = 1'b0;
        check("force_start_sr", 32'(bus.start_sr), 32'h2);
        check("force_ref_en_old", 32'(bus.ref_en_old), 32'h1);
        tick();
        bus.ref_done = 4'b0100;
        tick();
        tick();
        check("force_foreign_done_ignored", 32'(bus.ref_en_cur), 32'h2);
        enable_i     = 1'b0;
        bus.ref_done = 4'b0010;
        tick();
        bus.ref_done = '0;
        check("drop_next_busy", 32'(busy_o), 32'd1);
        check("err_sticky", 32'(timeout_err_o), 32'd1);
        tick();
        check("drop_idle_busy", 32'(busy_o), 32'd0);
        check("drop_idle_cur_bank", 32'(cur_bank_o), 32'd2);
        wait_start(20, lat);
        check("drop_no_start", 32'(lat), 32'hFFFF_FFFF);

        // Reset in the middle of a refresh.
        enable_i = 1'b1;
        wait_start(40, lat);
        check("re_enable_latency", 32'(lat), 32'd17);
        check("re_enable_start_sr", 32'(bus.start_sr), 32'h4);
        tick();
        rst      = 1'b1;
        enable_i = 1'b0;
        tick();
        check("mid_rst_ref_en_cur", 32'(bus.ref_en_cur), 32'h0);
        check("mid_rst_ref_en_old", 32'(bus.ref_en_old), 32'h0);
        check("mid_rst_cur_bank", 32'(cur_bank_o), 32'd0);
        check("mid_rst_old_bank", 32'(old_bank_o), 32'd3);
        check("mid_rst_timeout_err", 32'(timeout_err_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(bus.start_sr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
